mips_prog_loader: RTL and testbench

//  Writes the MIPS instruction/data memory at power-up, replacing backdoor memory loads.

---
 rtl/mips_prog_loader.sv | 202 ++++++++++++++++++++
 tb/tb_mips_prog_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// Power-up program loader for the MIPS core.
// Parses a framed byte stream (SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO,
// 4*CNT data bytes MSB first, CSUM) and writes big-endian 32-bit words to
// consecutive memory word addresses. Holds the processor halted until a
// frame with a matching XOR checksum has been loaded.
// Ports:
//   clk1      - clock, rising edge
//   reset     - synchronous, active-high
//   in_data   - stream byte
//   in_valid  - in_data valid
//   in_ready  - loader accepts a byte (low only in the frame-result cycle)
//   mem_we    - one-cycle memory write strobe
//   mem_addr  - word address for mem_we
//   mem_wdata - word for mem_we
//   start_pc  - start address of the last good frame
//   cpu_hold  - processor halt request, 1 = stalled
//   load_done - one-cycle pulse, frame checksum good
//   load_err  - one-cycle pulse, frame checksum bad
module mips_prog_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] start_pc,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM
    } state_t;

    state_t state_q, state_d;

    logic              accept;
    logic [CNT_W-1:0]  cnt_in;

    logic [7:0]        addr_hi_q,    addr_hi_d;
    logic [7:0]        cnt_hi_q,     cnt_hi_d;
    logic [ADDR_W-1:0] frame_addr_q, frame_addr_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic [1:0]        byte_idx_q,   byte_idx_d;
    logic [23:0]       word_q,       word_d;
    logic [7:0]        csum_q,       csum_d;

    logic              in_ready_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [31:0]       mem_wdata_d;
    logic [ADDR_W-1:0] start_pc_d;
    logic              cpu_hold_d;
    logic              load_done_d;
    logic              load_err_d;

    assign accept = in_valid & in_ready;
    assign cnt_in = {cnt_hi_q, in_data};

    // State register
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transition consumes one accepted byte
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                S_IDLE:    if (in_data == SYNC) state_d = S_ADDR_HI;
                S_ADDR_HI: state_d = S_ADDR_LO;
                S_ADDR_LO: state_d = S_CNT_HI;
                S_CNT_HI:  state_d = S_CNT_LO;
                S_CNT_LO:  state_d = (cnt_in != '0) ? S_DATA : S_CSUM;
                S_DATA:    if (byte_idx_q == 2'd3 && words_left_q == CNT_W'(1)) state_d = S_CSUM;
                S_CSUM:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        addr_hi_d    = addr_hi_q;
        cnt_hi_d     = cnt_hi_q;
        frame_addr_d = frame_addr_q;
        wr_addr_d    = wr_addr_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        csum_d       = csum_q;
        in_ready_d   = 1'b1;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        start_pc_d   = start_pc;
        cpu_hold_d   = cpu_hold;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;
        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    // A reload re-halts the processor as soon as SYNC is seen
                    if (in_data == SYNC) cpu_hold_d = 1'b1;
                end
                S_ADDR_HI: addr_hi_d = in_data;
                S_ADDR_LO: frame_addr_d = ADDR_W'({addr_hi_q, in_data});
                S_CNT_HI:  cnt_hi_d = in_data;
                S_CNT_LO: begin
                    words_left_d = cnt_in;
                    wr_addr_d    = frame_addr_q;
                    byte_idx_d   = 2'd0;
                    csum_d       = 8'd0;
                end
                S_DATA: begin
                    word_d     = {word_q[15:0], in_data};
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = wr_addr_q;
                        mem_wdata_d  = {word_q, in_data};
                        // Address wraps naturally at 2**ADDR_W
                        wr_addr_d    = wr_addr_q + ADDR_W'(1);
                        words_left_d = words_left_q - CNT_W'(1);
                    end
                end
                S_CSUM: begin
                    in_ready_d = 1'b0;
                    if (in_data == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                        start_pc_d  = frame_addr_q;
                    end else begin
                        load_err_d  = 1'b1;
                        cpu_hold_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk1) begin
        if (reset) begin
            addr_hi_q    <= '0;
            cnt_hi_q     <= '0;
            frame_addr_q <= '0;
            wr_addr_q    <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            in_ready     <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            start_pc     <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            addr_hi_q    <= addr_hi_d;
            cnt_hi_q     <= cnt_hi_d;
            frame_addr_q <= frame_addr_d;
            wr_addr_q    <= wr_addr_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            in_ready     <= in_ready_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            start_pc     <= start_pc_d;
            cpu_hold     <= cpu_hold_d;
            load_done    <= load_done_d;
            load_err     <= load_err_d;
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: table of single-word frames
// plus directed multi-cycle sequences (program load, bad checksum, address
// wrap, mid-frame reset, paused stream, empty frame).
module tb_mips_prog_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk1;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W-1:0] start_pc;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    mips_prog_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .start_pc  (start_pc),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        logic [15:0]       addr;
        logic [31:0]       data;
        bit                flip;
        logic [ADDR_W-1:0] exp_addr;
        bit                exp_done;
        logic [ADDR_W-1:0] exp_pc;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] words[16];
    logic [31:0] tb_mem[1024];
    int          total = 0;
    int          bad = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    bit          prev_we = 1'b0;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image and pulse counters, sampled on the falling edge
    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            tb_mem[mem_addr] = mem_wdata;
            last_wr_addr = mem_addr;
            we_cnt++;
            chk("we_spacing", 32'(prev_we), 32'd0);
        end
        prev_we = (mem_we === 1'b1);
        if (load_done === 1'b1) done_cnt++;
        if (load_err === 1'b1) err_cnt++;
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(1, 0) == 1) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(negedge clk1);
                end
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 8) begin
            @(negedge clk1);
            guard++;
        end
        if (guard == 8) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic send_frame(input logic [15:0] addr, input int n, input bit flip, input bit gaps);
        logic [7:0]        csum;
        logic [7:0]        b;
        logic [15:0]       cnt;
        logic [ADDR_W-1:0] exp_addr;
        csum     = 8'd0;
        cnt      = 16'(n);
        exp_addr = ADDR_W'(addr);
        send_byte(8'hA5, gaps);
        chk("hold_on_sync", 32'(cpu_hold), 32'd1);
        send_byte(addr[15:8], gaps);
        send_byte(addr[7:0], gaps);
        send_byte(cnt[15:8], gaps);
        send_byte(cnt[7:0], gaps);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b    = words[w][31 - 8*k -: 8];
                csum = csum ^ b;
                send_byte(b, gaps);
                if (k == 3) begin
                    chk("wr_strobe", 32'(mem_we), 32'd1);
                    chk("wr_addr", 32'(mem_addr), 32'(exp_addr));
                    chk("wr_data", mem_wdata, words[w]);
                    exp_addr = exp_addr + ADDR_W'(1);
                end
            end
        end
        send_byte(csum ^ {7'd0, flip}, gaps);
        in_valid = 1'b0;
        chk("done_pulse", 32'(load_done), 32'(!flip));
        chk("err_pulse", 32'(load_err), 32'(flip));
        chk("ready_low_result", 32'(in_ready), 32'd0);
        chk("hold_after_csum", 32'(cpu_hold), 32'(flip));
        @(negedge clk1);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic fill_prog();
        words[0]  = 32'h280a00c8;
        words[1]  = 32'h28020001;
        words[2]  = 32'h28030002;
        words[3]  = 32'h00432020;
        words[4]  = 32'h00831020;
        words[5]  = 32'hac020004;
        words[6]  = 32'h8c050004;
        words[7]  = 32'h20a50001;
        words[8]  = 32'h10a0fffe;
        words[9]  = 32'h00000000;
        words[10] = 32'hfc000000;
    endtask

    int we0, done0, err0;
    logic [31:0] prog[11];

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 16'd200,  data: 32'h0000000A, flip: 1'b0, exp_addr: 10'd200,  exp_done: 1'b1, exp_pc: 10'd200};
        vecs[1] = '{addr: 16'h0405, data: 32'hdeadbeef, flip: 1'b0, exp_addr: 10'd5,    exp_done: 1'b1, exp_pc: 10'd5};
        vecs[2] = '{addr: 16'd77,   data: 32'h12345678, flip: 1'b1, exp_addr: 10'd77,   exp_done: 1'b0, exp_pc: 10'd5};
        vecs[3] = '{addr: 16'hFFFF, data: 32'hcafef00d, flip: 1'b0, exp_addr: 10'd1023, exp_done: 1'b1, exp_pc: 10'd1023};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk1);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_pc", 32'(start_pc), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk1);

        // Program load, good checksum
        fill_prog();
        for (int i = 0; i < 11; i++) prog[i] = words[i];
        we0 = we_cnt; done0 = done_cnt; err0 = err_cnt;
        send_frame(16'd0, 11, 1'b0, 1'b0);
        @(negedge clk1);
        chk("t1_mem0", tb_mem[0], 32'h280a00c8);
        chk("t1_mem10", tb_mem[10], 32'hfc000000);
        chk("t1_we_count", 32'(we_cnt - we0), 32'd11);
        chk("t1_done_count", 32'(done_cnt - done0), 32'd1);
        chk("t1_err_count", 32'(err_cnt - err0), 32'd0);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_pc", 32'(start_pc), 32'd0);

        // Same frame, corrupted checksum
        we0 = we_cnt; done0 = done_cnt; err0 = err_cnt;
        send_frame(16'd0, 11, 1'b1, 1'b0);
        @(negedge clk1);
        chk("t2_we_count", 32'(we_cnt - we0), 32'd11);
        chk("t2_err_count", 32'(err_cnt - err0), 32'd1);
        chk("t2_done_count", 32'(done_cnt - done0), 32'd0);
        chk("t2_hold", 32'(cpu_hold), 32'd1);
        chk("t2_pc", 32'(start_pc), 32'd0);

        // Junk before SYNC must be dropped
        we0 = we_cnt; done0 = done_cnt; err0 = err_cnt;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h3C, 1'b0);
        in_valid = 1'b0;
        @(negedge clk1);
        chk("junk_no_we", 32'(we_cnt - we0), 32'd0);
        chk("junk_no_pulse", 32'(done_cnt - done0 + err_cnt - err0), 32'd0);

        // Single-word frame table
        for (int v = 0; v < 4; v++) begin
            words[0] = vecs[v].data;
            done0 = done_cnt; err0 = err_cnt;
            send_frame(vecs[v].addr, 1, vecs[v].flip, 1'b0);
            @(negedge clk1);
            chk($sformatf("vec%0d_wr_addr", v), 32'(last_wr_addr), 32'(vecs[v].exp_addr));
            chk($sformatf("vec%0d_mem", v), tb_mem[vecs[v].exp_addr], vecs[v].data);
            chk($sformatf("vec%0d_done", v), 32'(done_cnt - done0), 32'(vecs[v].exp_done));
            chk($sformatf("vec%0d_err", v), 32'(err_cnt - err0), 32'(!vecs[v].exp_done));
            chk($sformatf("vec%0d_hold", v), 32'(cpu_hold), 32'(!vecs[v].exp_done));
            chk($sformatf("vec%0d_pc", v), 32'(start_pc), 32'(vecs[v].exp_pc));
        end

        // Address wrap across the top of memory
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        send_frame(16'h03FF, 2, 1'b0, 1'b0);
        @(negedge clk1);
        chk("wrap_mem1023", tb_mem[1023], 32'h11111111);
        chk("wrap_mem0", tb_mem[0], 32'h22222222);
        chk("wrap_last_addr", 32'(last_wr_addr), 32'd0);
        chk("wrap_pc", 32'(start_pc), 32'd1023);

        // Reset after two data bytes of a word
        we0 = we_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h99, 1'b0);
        send_byte(8'h88, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk1);
        reset = 1'b0;
        @(negedge clk1);
        chk("abort_hold", 32'(cpu_hold), 32'd1);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_pc", 32'(start_pc), 32'd0);
        words[0] = 32'h33445566;
        done0 = done_cnt;
        send_frame(16'd6, 1, 1'b0, 1'b0);
        @(negedge clk1);
        chk("abort_we_count", 32'(we_cnt - we0), 32'd1);
        chk("abort_mem5_kept", tb_mem[5], 32'hdeadbeef);
        chk("abort_mem6", tb_mem[6], 32'h33445566);
        chk("abort_done", 32'(done_cnt - done0), 32'd1);
        chk("abort_pc_new", 32'(start_pc), 32'd6);

        // Program load with a paused stream
        fill_prog();
        we0 = we_cnt; done0 = done_cnt; err0 = err_cnt;
        send_frame(16'd0, 11, 1'b0, 1'b1);
        @(negedge clk1);
        for (int i = 0; i < 11; i++) chk($sformatf("t6_mem%0d", i), tb_mem[i], prog[i]);
        chk("t6_we_count", 32'(we_cnt - we0), 32'd11);
        chk("t6_done_count", 32'(done_cnt - done0), 32'd1);
        chk("t6_err_count", 32'(err_cnt - err0), 32'd0);
        chk("t6_hold", 32'(cpu_hold), 32'd0);

        // Empty frame: checksum 00, no writes
        we0 = we_cnt; done0 = done_cnt;
        send_frame(16'd50, 0, 1'b0, 1'b1);
        @(negedge clk1);
        chk("cnt0_we_count", 32'(we_cnt - we0), 32'd0);
        chk("cnt0_done", 32'(done_cnt - done0), 32'd1);
        chk("cnt0_pc", 32'(start_pc), 32'd50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
